sarray_deskew_collect: RTL

//  Output end of the systolic array: receives the row-staggered result stream from the array's right edge.
//   Row i arrives i cycles after row 0, mirroring the input skew applied on the feed side.
//  De-skews the rows back into one aligned word per result and checks row consistency.

---
 rtl/sarray_deskew_collect_pkg.sv | 19 +
 rtl/sarray_deskew_collect_row_delay_line.sv | 48 ++++
 rtl/sarray_deskew_collect.sv | 107 ++++++++++
 3 files changed

// File: rtl/sarray_deskew_collect_pkg.sv
// Shared sizing constants for the systolic-array output collector.
// Also holds a small FIFO pointer helper used by the collector.
package sarray_deskew_collect_pkg;

   localparam int SARRAY_H                 = 4;
   localparam int TMMA_CNT_WIDTH           = 8;
   localparam int PE_INPUT_DATA_WIDTH      = 32;
   localparam int SARRAY_DESKEW_FIFO_DEPTH = 8;

   // Wrap-bit pointers: same index with opposite lap bit means the ring is full.
   function automatic logic ptr_full(input logic [31:0] wr_ptr, input logic [31:0] rd_ptr,
                                     input int aw);
      logic [31:0] idx_mask;
      idx_mask = (32'd1 << aw) - 32'd1;
      return ((wr_ptr ^ rd_ptr) & ~idx_mask & (32'd1 << aw)) != 32'd0 &&
             ((wr_ptr & idx_mask) == (rd_ptr & idx_mask));
   endfunction

endpackage

// File: rtl/sarray_deskew_collect_row_delay_line.sv
// Fixed-length delay for one array row: valid plus a W-bit cnt/data payload.
// DELAY of zero collapses to a straight wire.
module row_delay_line #(
   parameter int DELAY = 0,
   parameter int W     = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         src_valid,
   input  logic [W-1:0] src_bits,
   output logic         dly_valid,
   output logic [W-1:0] dly_bits
);

   if (DELAY == 0) begin : g_pass
      logic unused_s;
      assign unused_s  = clk ^ rst;
      assign dly_valid = src_valid;
      assign dly_bits  = src_bits;
   end else begin : g_dly
      logic [DELAY-1:0] valid_r;
      logic [W-1:0]     bits_r [DELAY];

      // Valid chain is cleared on reset so in-flight rows never reach the aligner.
      always_ff @(posedge clk) begin
         if (rst) begin
            valid_r <= '0;
         end else begin
            valid_r[0] <= src_valid;
            for (int k = 1; k < DELAY; k++) begin
               valid_r[k] <= valid_r[k-1];
            end
         end
      end

      // Payload shifts unconditionally; it is qualified by the valid chain.
      always_ff @(posedge clk) begin
         bits_r[0] <= src_bits;
         for (int k = 1; k < DELAY; k++) begin
            bits_r[k] <= bits_r[k-1];
         end
      end

      assign dly_valid = valid_r[DELAY-1];
      assign dly_bits  = bits_r[DELAY-1];
   end

endmodule

// File: rtl/sarray_deskew_collect.sv
// De-skews the staggered row results of the systolic array, checks row alignment
// and queues aligned words in a first-word-fall-through FIFO for writeback.
module sarray_deskew_collect
   import sarray_deskew_collect_pkg::*;
#(
   parameter int ROWS       = SARRAY_H,
   parameter int DATA_W     = PE_INPUT_DATA_WIDTH,
   parameter int CNT_W      = TMMA_CNT_WIDTH,
   parameter int FIFO_DEPTH = SARRAY_DESKEW_FIFO_DEPTH
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [ROWS-1:0]        row_valid_i,
   input  logic [CNT_W*ROWS-1:0]  row_cnt_i,
   input  logic [DATA_W*ROWS-1:0] row_data_i,
   output logic                   space_ok_o,
   output logic                   rd_valid_o,
   input  logic                   rd_ready_i,
   output logic [CNT_W-1:0]       rd_cnt_o,
   output logic [DATA_W*ROWS-1:0] rd_data_o,
   input  logic                   err_clr_i,
   output logic                   err_o,
   output logic                   ovf_o
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int PW = AW + 1;
   localparam int RW = CNT_W + DATA_W;
   localparam int EW = CNT_W + DATA_W * ROWS;

   logic [ROWS-1:0]        dsk_valid_s;
   logic [RW-1:0]          dsk_bits_s [ROWS];
   logic [CNT_W-1:0]       dsk_cnt_s  [ROWS];
   logic [DATA_W*ROWS-1:0] dsk_data_s;

   for (genvar i = 0; i < ROWS; i++) begin : g_row
      row_delay_line #(.DELAY(ROWS - 1 - i), .W(RW)) u_dly (
         .clk       (clk),
         .rst       (rst),
         .src_valid (row_valid_i[i]),
         .src_bits  ({row_cnt_i[i*CNT_W +: CNT_W], row_data_i[i*DATA_W +: DATA_W]}),
         .dly_valid (dsk_valid_s[i]),
         .dly_bits  (dsk_bits_s[i])
      );
      assign dsk_cnt_s[i]                    = dsk_bits_s[i][RW-1 -: CNT_W];
      assign dsk_data_s[i*DATA_W +: DATA_W] = dsk_bits_s[i][DATA_W-1:0];
   end

   logic cnt_eq_s, push_req_s, err_set_s;

   // A word is aligned only when every row is valid and carries row 0's counter.
   always_comb begin
      cnt_eq_s = 1'b1;
      for (int i = 1; i < ROWS; i++) begin
         cnt_eq_s = cnt_eq_s & (dsk_cnt_s[i] == dsk_cnt_s[0]);
      end
   end

   assign push_req_s = (&dsk_valid_s) & cnt_eq_s;
   assign err_set_s  = (|dsk_valid_s) & ~push_req_s;

   logic [EW-1:0] mem_r [FIFO_DEPTH];
   logic [PW-1:0] wr_ptr_r, rd_ptr_r, wr_ptr_nx_s, rd_ptr_nx_s, occ_nx_s;
   logic          full_s, pop_s, push_s, ovf_set_s;
   logic          rd_valid_r, space_ok_r, err_r, ovf_r;

   assign full_s      = ptr_full(32'(wr_ptr_r), 32'(rd_ptr_r), AW);
   assign pop_s       = rd_valid_r & rd_ready_i;
   assign push_s      = push_req_s & (~full_s | pop_s);
   assign ovf_set_s   = push_req_s & full_s & ~pop_s;
   assign wr_ptr_nx_s = wr_ptr_r + PW'(push_s);
   assign rd_ptr_nx_s = rd_ptr_r + PW'(pop_s);
   assign occ_nx_s    = wr_ptr_nx_s - rd_ptr_nx_s;

   // Pointers, registered status outputs and sticky error flags.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_r   <= '0;
         rd_ptr_r   <= '0;
         rd_valid_r <= 1'b0;
         space_ok_r <= 1'b1;
         err_r      <= 1'b0;
         ovf_r      <= 1'b0;
      end else begin
         wr_ptr_r   <= wr_ptr_nx_s;
         rd_ptr_r   <= rd_ptr_nx_s;
         rd_valid_r <= (occ_nx_s != PW'(0));
         space_ok_r <= ((PW'(FIFO_DEPTH) - occ_nx_s) >= PW'(ROWS));
         err_r      <= err_set_s | (err_r & ~err_clr_i);
         ovf_r      <= ovf_set_s | (ovf_r & ~err_clr_i);
      end
   end

   // Storage is not reset; occupancy is tracked purely by the pointers.
   always_ff @(posedge clk) begin
      if (push_s) begin
         mem_r[wr_ptr_r[AW-1:0]] <= {dsk_cnt_s[0], dsk_data_s};
      end
   end

   assign {rd_cnt_o, rd_data_o} = mem_r[rd_ptr_r[AW-1:0]];
   assign rd_valid_o = rd_valid_r;
   assign space_ok_o = space_ok_r;
   assign err_o      = err_r;
   assign ovf_o      = ovf_r;

endmodule
